// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the baud divider helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per serial bit; integer division, shared with the receiver.
    function automatic int unsigned clk_divide(input int unsigned clk_freq,
                                               input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLK_DIVIDE-1 down to 0 and pulses tick for one cycle at 0.
module uart_baud_tick #(
    parameter int unsigned CLK_DIVIDE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIVIDE > 2) ? $clog2(CLK_DIVIDE) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIVIDE - 1);

    logic [CNT_W-1:0] count;

    // Down-counter; restart realigns the bit period to the current cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (restart || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - CNT_W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, LSB-first start/data/stop frame out on tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy
);

    localparam int unsigned CLK_DIVIDE = clk_divide(CLK_FREQ, BAUD_RATE);
    localparam int unsigned IDX_W      = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    // Reject configurations the bit timing or framing cannot support.
    if (CLK_DIVIDE < 2) begin : g_bad_divide
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  restart_c;
    logic                  tick_c;

    uart_baud_tick #(
        .CLK_DIVIDE (CLK_DIVIDE)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_c),
        .tick    (tick_c)
    );

    // State, shift register, bit index and line register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state and next-line-value decode; the line value is computed one cycle ahead.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        restart_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    shift_d   = tx_data_in;
                    idx_d     = '0;
                    restart_c = 1'b1;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (tick_c) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_d[0];
                    end
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (tick_c) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLK_DIVIDE=10 (1 and 2 stop bits).
module tb_uart_tx;

    localparam int unsigned DW     = 8;
    localparam int unsigned CF     = 1000000;
    localparam int unsigned BR     = 100000;
    localparam int unsigned CD     = CF / BR;
    localparam int unsigned FRAME1 = (1 + DW + 1) * CD;
    localparam int unsigned FRAME2 = (1 + DW + 2) * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tx_data_in;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic          tx_busy;
    logic [DW-1:0] d2;
    logic          v2;
    logic          rdy2;
    logic          tx2;
    logic          busy2;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            frames_done = 0;
    int unsigned   cyc = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp2_q[$];
    int unsigned   start_cyc[$];

    uart_tx #(.DATA_WIDTH(DW), .CLK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data_in(tx_data_in), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy)
    );

    uart_tx #(.DATA_WIDTH(DW), .CLK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data_in(d2), .tx_valid(v2),
        .tx_ready(rdy2), .tx(tx2), .tx_busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Ideal line level for bit slot k of a frame carrying w: start, LSB-first data, stop(s).
    function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= int'(DW)) return w[k-1];
        return 1'b1;
    endfunction

    // Every handshake pushes the accepted word as the expected next frame.
    always @(posedge clk) begin
        if (rst && tx_valid && tx_ready) exp_q.push_back(tx_data_in);
        if (rst && v2 && rdy2) exp2_q.push_back(d2);
    end

    // Monitor: capture each frame on the line, pop its expectation and compare.
    initial begin : monitor
        logic          prev;
        logic          s [0:FRAME1-1];
        logic          aborted;
        int            busy_low;
        int            wave_err;
        logic [DW-1:0] w;
        logic [DW-1:0] dec;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && prev && !tx) begin
                start_cyc.push_back(cyc);
                aborted  = 1'b0;
                busy_low = tx_busy ? 0 : 1;
                s[0]     = tx;
                for (int i = 1; i < int'(FRAME1); i++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = tx;
                    if (!tx_busy) busy_low++;
                end
                if (!aborted) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame_expected: got frame with empty queue, required none (cycle %0d)", cyc);
                    end else begin
                        w = exp_q.pop_front();
                        wave_err = 0;
                        for (int i = 0; i < int'(FRAME1); i++)
                            if (s[i] !== exp_bit(w, i / int'(CD))) wave_err++;
                        for (int b = 0; b < int'(DW); b++) dec[b] = s[(b + 1) * int'(CD) + int'(CD) / 2];
                        check("frame_wave_errors", wave_err, 0);
                        check("frame_word", int'(dec), int'(w));
                    end
                    check("busy_low_in_frame", busy_low, 0);
                    @(negedge clk);
                    if (rst) begin
                        check("idle_ready_after_frame", int'(tx_ready), 1);
                        check("idle_busy_after_frame", int'(tx_busy), 0);
                    end
                    frames_done++;
                end
            end
            prev = rst ? tx : 1'b1;
        end
    end

    task automatic send(input logic [DW-1:0] w);
        int k;
        tx_data_in = w;
        tx_valid   = 1'b1;
        for (k = 0; k < 2000 && !tx_ready; k++) @(negedge clk);
        check("send_ready", int'(tx_ready), 1);
        @(negedge clk);
        tx_valid   = 1'b0;
        tx_data_in = DW'($urandom);
    endtask

    task automatic wait_frames(input int target);
        for (int k = 0; k < 5000 && frames_done < target; k++) @(negedge clk);
        check("frames_done", frames_done, target);
    endtask

    // Two-stop-bit instance: sample the whole frame directly against the model.
    task automatic run_stop2();
        logic [DW-1:0] w;
        int            wave_err;
        int            busy_cnt;
        int            stop_hi;
        logic          s [0:FRAME2-1];
        @(negedge clk);
        d2 = 8'h0F;
        v2 = 1'b1;
        check("stop2_ready", int'(rdy2), 1);
        @(negedge clk);
        v2 = 1'b0;
        d2 = DW'($urandom);
        busy_cnt = 0;
        for (int i = 0; i < int'(FRAME2); i++) begin
            s[i] = tx2;
            if (busy2) busy_cnt++;
            @(negedge clk);
        end
        check("stop2_busy_cycles", busy_cnt, int'(FRAME2));
        check("stop2_busy_after", int'(busy2), 0);
        n_cmp++;
        if (exp2_q.size() == 0) begin
            n_fail++;
            $display("FAIL stop2_expected: got empty queue, required one word");
        end else begin
            w = exp2_q.pop_front();
            wave_err = 0;
            stop_hi  = 0;
            for (int i = 0; i < int'(FRAME2); i++)
                if (s[i] !== exp_bit(w, i / int'(CD))) wave_err++;
            for (int i = int'((1 + DW) * CD); i < int'(FRAME2); i++)
                if (s[i] === 1'b1) stop_hi++;
            check("stop2_wave_errors", wave_err, 0);
            check("stop2_stop_high_cycles", stop_hi, int'(2 * CD));
        end
    endtask

    initial begin : stimulus
        int base;
        int gap;
        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data_in = '0;
        v2         = 1'b0;
        d2         = '0;
        #3 rst = 1'b0;
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_ready", int'(tx_ready), 1);
        check("reset_busy", int'(tx_busy), 0);
        check("reset_tx2", int'(tx2), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single word right after reset release.
        send(8'hA5);
        wait_frames(1);

        // Back-to-back with tx_valid held high: 0x00 then 0xFF.
        start_cyc.delete();
        @(negedge clk);
        tx_data_in = 8'h00;
        tx_valid   = 1'b1;
        for (int k = 0; k < 50 && !tx_ready; k++) @(negedge clk);
        @(negedge clk);
        tx_data_in = 8'hFF;
        gap = 0;
        for (int k = 0; k < 500 && !tx_ready; k++) begin
            gap++;
            @(negedge clk);
        end
        check("b2b_not_ready_cycles", gap, int'(FRAME1));
        @(negedge clk);
        tx_valid = 1'b0;
        wait_frames(3);
        check("b2b_start_count", start_cyc.size(), 2);
        if (start_cyc.size() >= 2)
            check("b2b_start_spacing", int'(start_cyc[1] - start_cyc[0]), int'(FRAME1) + 1);

        // Valid pulse and data changes while busy are ignored.
        base = frames_done;
        send(8'h81);
        repeat (38) @(negedge clk);
        tx_valid   = 1'b1;
        tx_data_in = 8'h3C;
        check("busy_ready_low", int'(tx_ready), 0);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (20) begin
            tx_data_in = DW'($urandom);
            @(negedge clk);
        end
        wait_frames(base + 1);
        repeat (30) @(negedge clk);
        check("busy_no_extra_frame", frames_done, base + 1);
        check("busy_queue_empty", exp_q.size(), 0);

        // Random words with random idle gaps.
        base = frames_done;
        for (int n = 0; n < 6; n++) begin
            send(DW'($urandom));
            gap = int'($urandom_range(0, 5));
            repeat (gap) @(negedge clk);
        end
        wait_frames(base + 6);

        // Reset in the middle of a frame drops the word.
        base = frames_done;
        send(DW'($urandom));
        repeat (33) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_tx", int'(tx), 1);
        check("midreset_ready", int'(tx_ready), 1);
        check("midreset_busy", int'(tx_busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        check("midreset_frame_dropped", frames_done, base);
        send(8'h5A);
        wait_frames(base + 1);

        run_stop2();

        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
